// File: rtl/seq_pattern_gen_if.sv
// Serial pattern generator control/data bundle.
// The master drives the requests; the slave (the generator) returns the serial stream and status.
interface seq_pattern_gen_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4
);
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic [CNT_W-1:0] gap_len;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, pattern, repeat_cnt, gap_len,
    input  dout, dout_valid, busy, done
  );

  modport slave (
    input  start, abort, pattern, repeat_cnt, gap_len,
    output dout, dout_valid, busy, done
  );
endinterface

// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern transmitter: sends a latched pattern MSB-first, repeat_cnt times,
// with gap_len idle cycles between repetitions, then pulses done.
//
// state   | meaning
// S_IDLE  | waiting for start; outputs at idle level
// S_SHIFT | one pattern bit on dout per cycle
// S_GAP   | idle cycles between repetitions
// S_DONE  | single done cycle, then back to idle
module seq_pattern_gen #(
  parameter int   PAT_W    = 4,
  parameter int   CNT_W    = 4,
  parameter logic IDLE_LVL = 1'b1
) (
  input logic               clk,
  input logic               reset,
  seq_pattern_gen_if.slave  bus
);

  localparam int BIT_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q,   state_d;
  logic [PAT_W-1:0] pat_q,     pat_d;
  logic [PAT_W-1:0] sh_q,      sh_d;
  logic [CNT_W-1:0] rep_q,     rep_d;
  logic [CNT_W-1:0] gap_q,     gap_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             dout_q,    dout_d;
  logic             valid_q,   valid_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic             restart;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pat_q     <= '0;
      sh_q      <= '0;
      rep_q     <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      bit_cnt_q <= '0;
      dout_q    <= IDLE_LVL;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      sh_q      <= sh_d;
      rep_q     <= rep_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    sh_d      = sh_q;
    rep_d     = rep_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    bit_cnt_d = bit_cnt_q;
    dout_d    = IDLE_LVL;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    restart   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // abort beats a simultaneous start
        if (bus.start && !bus.abort) begin
          pat_d  = bus.pattern;
          rep_d  = bus.repeat_cnt;
          gap_d  = bus.gap_len;
          busy_d = 1'b1;
          if (bus.repeat_cnt == CNT_ZERO) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = S_SHIFT;
            dout_d    = bus.pattern[PAT_W-1];
            valid_d   = 1'b1;
            sh_d      = {bus.pattern[PAT_W-2:0], 1'b0};
            bit_cnt_d = '0;
          end
        end
      end

      S_SHIFT: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (bit_cnt_q == BIT_LAST) begin
          busy_d = 1'b1;
          rep_d  = rep_q - CNT_ONE;
          if (rep_q == CNT_ONE) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (gap_q != CNT_ZERO) begin
            state_d   = S_GAP;
            gap_cnt_d = gap_q - CNT_ONE;
          end else begin
            restart = 1'b1;
          end
        end else begin
          busy_d    = 1'b1;
          dout_d    = sh_q[PAT_W-1];
          valid_d   = 1'b1;
          sh_d      = {sh_q[PAT_W-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end

      S_GAP: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (gap_cnt_q == CNT_ZERO) begin
          busy_d  = 1'b1;
          restart = 1'b1;
        end else begin
          busy_d    = 1'b1;
          gap_cnt_d = gap_cnt_q - CNT_ONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // next repetition begins with the MSB of the latched pattern
    if (restart) begin
      state_d   = S_SHIFT;
      dout_d    = pat_q[PAT_W-1];
      valid_d   = 1'b1;
      sh_d      = {pat_q[PAT_W-2:0], 1'b0};
      bit_cnt_d = '0;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: a queue model of the expected output stream checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_seq_pattern_gen;
  localparam int   PAT_W    = 4;
  localparam int   CNT_W    = 4;
  localparam logic IDLE_LVL = 1'b1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_pattern_gen_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

  seq_pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .IDLE_LVL(IDLE_LVL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Expected output per cycle: {dout, valid, busy, done}
  localparam logic [3:0] IDLE_E = {IDLE_LVL, 3'b000};
  logic [3:0] exp_q[$];
  logic [3:0] cur = IDLE_E;
  bit started = 1'b0;

  task automatic build(input logic [PAT_W-1:0] pat, input int r_cnt, input int g_len);
    for (int r = 0; r < r_cnt; r++) begin
      for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back({pat[b], 3'b110});
      if (r < r_cnt - 1)
        for (int g = 0; g < g_len; g++) exp_q.push_back({IDLE_LVL, 3'b010});
    end
    exp_q.push_back({IDLE_LVL, 3'b011});
  endtask

  always @(posedge clk) begin
    started = 1'b1;
    if (reset) begin
      exp_q.delete();
      cur = IDLE_E;
    end else if (cur[1]) begin
      if (bus.abort) begin
        exp_q.delete();
        cur = IDLE_E;
      end else if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
      end else begin
        cur = IDLE_E;
      end
    end else if (bus.start && !bus.abort) begin
      build(bus.pattern, int'(bus.repeat_cnt), int'(bus.gap_len));
      cur = exp_q.pop_front();
    end
  end

  // Monitor accumulators for the literal expectations
  int          busy_cnt, done_cnt, nvalid, det_cnt;
  logic [63:0] vbits;
  logic [3:0]  hist;

  task automatic clear_mon();
    busy_cnt = 0; done_cnt = 0; nvalid = 0; det_cnt = 0;
    vbits = '0; hist = 4'b1111;
  endtask

  always @(posedge clk) begin
    #1;
    if (started) begin
      chk("cyc_dout",  {63'd0, bus.dout},       {63'd0, cur[3]});
      chk("cyc_valid", {63'd0, bus.dout_valid}, {63'd0, cur[2]});
      chk("cyc_busy",  {63'd0, bus.busy},       {63'd0, cur[1]});
      chk("cyc_done",  {63'd0, bus.done},       {63'd0, cur[0]});
      if (bus.busy) busy_cnt++;
      if (bus.done) done_cnt++;
      if (bus.dout_valid) begin
        vbits = {vbits[62:0], bus.dout};
        nvalid++;
      end
      hist = {hist[2:0], bus.dout};
      if (hist == 4'b0101) det_cnt++;
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Start pulse, then scramble the inputs to show they were latched
  task automatic send(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] r, input logic [CNT_W-1:0] g);
    @(negedge clk);
    bus.pattern = pat; bus.repeat_cnt = r; bus.gap_len = g; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.pattern = ~pat; bus.repeat_cnt = 4'd7; bus.gap_len = 4'd5;
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.pattern = '0; bus.repeat_cnt = '0; bus.gap_len = '0;
    clear_mon();
    run(3);
    reset = 1'b0;
    chk("rst_dout",  {63'd0, bus.dout},       64'd1);
    chk("rst_valid", {63'd0, bus.dout_valid}, 64'd0);
    chk("rst_busy",  {63'd0, bus.busy},       64'd0);
    chk("rst_done",  {63'd0, bus.done},       64'd0);

    // single repetition, no gap
    clear_mon();
    send(4'b0101, 4'd1, 4'd0);
    run(8);
    chk("t1_busy",   busy_cnt, 64'd5);
    chk("t1_nvalid", nvalid, 64'd4);
    chk("t1_bits",   {60'd0, vbits[3:0]}, 64'h5);
    chk("t1_done",   done_cnt, 64'd1);

    // back-to-back repetitions
    clear_mon();
    send(4'b0101, 4'd3, 4'd0);
    run(16);
    chk("t2_nvalid", nvalid, 64'd12);
    chk("t2_bits",   {52'd0, vbits[11:0]}, 64'h555);
    chk("t2_det",    det_cnt, 64'd5);
    chk("t2_busy",   busy_cnt, 64'd13);

    // repetitions separated by a gap
    clear_mon();
    send(4'b0101, 4'd2, 4'd2);
    run(14);
    chk("t3_busy",   busy_cnt, 64'd11);
    chk("t3_det",    det_cnt, 64'd2);
    chk("t3_nvalid", nvalid, 64'd8);

    // zero repeats
    clear_mon();
    send(4'b0101, 4'd0, 4'd3);
    run(4);
    chk("t4_nvalid", nvalid, 64'd0);
    chk("t4_busy",   busy_cnt, 64'd1);
    chk("t4_done",   done_cnt, 64'd1);

    // abort on the third bit, then a fresh start one cycle later
    clear_mon();
    @(negedge clk);
    bus.pattern = 4'b0101; bus.repeat_cnt = 4'd2; bus.gap_len = 4'd0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    run(2);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("t5_abort_busy", {63'd0, bus.busy}, 64'd0);
    chk("t5_abort_nv",   nvalid, 64'd3);
    clear_mon();
    bus.pattern = 4'b1100; bus.repeat_cnt = 4'd1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    run(7);
    chk("t5_bits",   {60'd0, vbits[3:0]}, 64'hC);
    chk("t5_nvalid", nvalid, 64'd4);
    chk("t5_done",   done_cnt, 64'd1);

    // abort together with start in idle drops the start
    clear_mon();
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    run(3);
    chk("t5b_busy", busy_cnt, 64'd0);

    // start held during shift, then reset in the gap
    clear_mon();
    @(negedge clk);
    bus.pattern = 4'b0110; bus.repeat_cnt = 4'd2; bus.gap_len = 4'd3; bus.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.pattern = 4'b1111; bus.repeat_cnt = 4'd1; bus.gap_len = 4'd0;
    end
    bus.start = 1'b0;
    run(2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_dout",   {63'd0, bus.dout},       64'd1);
    chk("t6_valid",  {63'd0, bus.dout_valid}, 64'd0);
    chk("t6_busy",   {63'd0, bus.busy},       64'd0);
    chk("t6_done",   {63'd0, bus.done},       64'd0);
    chk("t6_bits",   {60'd0, vbits[3:0]}, 64'h6);
    chk("t6_nvalid", nvalid, 64'd4);
    run(5);
    chk("t6_nodone", done_cnt, 64'd0);

    // maximum repeat count
    clear_mon();
    send(4'b1001, 4'd15, 4'd0);
    run(65);
    chk("t7_busy",   busy_cnt, 64'd61);
    chk("t7_nvalid", nvalid, 64'd60);
    chk("t7_done",   done_cnt, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
